// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues icache requests, buffers responses in a circular
// FIFO for the decoder, and handles ROB flush redirects, including stale responses.
module inst_fetch_queue #(
  parameter int                DEPTH_LOG2 = 2,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear_up,
  input  logic [ADDR_W-1:0]     rob_next_pc,
  output logic [ADDR_W-1:0]     pc,
  output logic                  start_fetch,
  input  logic                  fetch_ready,
  input  logic [31:0]           inst,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [ADDR_W-1:0]     pred_pc,
  output logic [31:0]           pred_inst,
  input  logic [ADDR_W-1:0]     pred_next_pc,
  output logic                  out_valid,
  output logic [31:0]           out_inst,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_is_i,
  input  logic                  issue_signal,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic                    start_fetch_q, start_fetch_d;
  logic [DEPTH_LOG2-1:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    push, pop;

  logic [31:0]             inst_mem [DEPTH];
  logic [ADDR_W-1:0]       addr_mem [DEPTH];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push    = 1'b0;
    pop     = issue_signal && (count_q != '0);

    if (rob_clear_up) begin
      // Flush: the pending request is stale unless it is being answered right now.
      pop     = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = rob_next_pc;
      state_d = (fetch_ready || state_q == S_WAIT) ? S_FETCH : S_DROP;
    end else begin
      unique case (state_q)
        S_FETCH: if (fetch_ready) begin
          push = 1'b1;
          pc_d = pred_next_pc;
        end
        S_WAIT:  if (pop)         state_d = S_FETCH;
        S_DROP:  if (fetch_ready) state_d = S_FETCH;
        default:                  state_d = S_FETCH;
      endcase

      if (pop)  head_d = head_q + DEPTH_LOG2'(1);
      if (push) tail_d = tail_q + DEPTH_LOG2'(1);
      count_d = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
      if (push) state_d = (count_d < FULL_CNT) ? S_FETCH : S_WAIT;
    end

    start_fetch_d = (state_d == S_FETCH);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      start_fetch_q <= 1'b1;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      start_fetch_q <= start_fetch_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates out_valid, so stale contents are never consumed.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      inst_mem[tail_q] <= inst;
      addr_mem[tail_q] <= inst_addr;
    end
  end

  assign pc          = pc_q;
  assign start_fetch = start_fetch_q;
  assign count       = count_q;
  assign pred_pc     = inst_addr;
  assign pred_inst   = inst;
  assign out_valid   = (count_q != '0);
  assign out_inst    = inst_mem[head_q];
  assign out_addr    = addr_mem[head_q];
  assign out_is_i    = out_valid && (out_inst[1:0] == 2'b11);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int AW    = 32;

  logic           clk_in = 1'b0;
  logic           rst_in, rdy_in, rob_clear_up, fetch_ready, issue_signal;
  logic [AW-1:0]  rob_next_pc, inst_addr, pred_next_pc;
  logic [31:0]    inst;
  logic [AW-1:0]  pc, pred_pc, out_addr;
  logic [31:0]    pred_inst, out_inst;
  logic           start_fetch, out_valid, out_is_i;
  logic [DL2:0]   count;

  inst_fetch_queue #(.DEPTH_LOG2(DL2), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_clear_up(rob_clear_up), .rob_next_pc(rob_next_pc),
    .pc(pc), .start_fetch(start_fetch), .fetch_ready(fetch_ready),
    .inst(inst), .inst_addr(inst_addr),
    .pred_pc(pred_pc), .pred_inst(pred_inst), .pred_next_pc(pred_next_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_addr(out_addr),
    .out_is_i(out_is_i), .issue_signal(issue_signal), .count(count)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, pending-request flags and the next fetch address.
  typedef struct packed {
    logic [31:0]   inst;
    logic [AW-1:0] addr;
  } ent_t;

  ent_t          mq[$];
  bit            m_req;   // request outstanding and start_fetch high
  bit            m_drop;  // stale request outstanding
  logic [AW-1:0] m_pc;

  task automatic model_step();
    bit outst;
    bit do_pop;
    if (rst_in) begin
      mq.delete();
      m_pc = '0; m_req = 1'b1; m_drop = 1'b0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        outst = m_req || m_drop;
        mq.delete();
        m_pc = rob_next_pc;
        if (fetch_ready || !outst) begin m_req = 1'b1; m_drop = 1'b0; end
        else                       begin m_req = 1'b0; m_drop = 1'b1; end
      end else begin
        do_pop = issue_signal && (mq.size() != 0);
        if (do_pop) void'(mq.pop_front());
        if (fetch_ready && m_req) begin
          mq.push_back(ent_t'{inst: inst, addr: inst_addr});
          m_pc  = pred_next_pc;
          m_req = (mq.size() < DEPTH);
        end else if (fetch_ready && m_drop) begin
          m_drop = 1'b0; m_req = 1'b1;
        end else if (do_pop && !m_req && !m_drop) begin
          m_req = 1'b1;
        end
      end
    end
  endtask

  // Compare process: outputs sampled mid-cycle, away from the rising edge.
  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("pc", pc, m_pc);
      check("start_fetch", start_fetch, m_req);
      check("count", count, mq.size());
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_inst", out_inst, mq[0].inst);
        check("out_addr", out_addr, mq[0].addr);
        check("out_is_i", out_is_i, mq[0].inst[1:0] == 2'b11);
      end else begin
        check("out_is_i_empty", out_is_i, 1'b0);
      end
      check("pred_pc", pred_pc, inst_addr);
      check("pred_inst", pred_inst, inst);
      if (!rst_in && rdy_in && !rob_clear_up && start_fetch && fetch_ready)
        check("no_full_push", count < DEPTH, 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle();
    fetch_ready = 1'b0; issue_signal = 1'b0; rob_clear_up = 1'b0;
  endtask

  task automatic resp(input logic [AW-1:0] a, input logic [31:0] i, input logic [AW-1:0] n);
    fetch_ready = 1'b1; inst_addr = a; inst = i; pred_next_pc = n;
  endtask

  task automatic expect_lit(input string tag, input int cnt, input logic [AW-1:0] p, input bit sf);
    check({tag, "_count"}, count, cnt);
    check({tag, "_pc"}, pc, p);
    check({tag, "_start_fetch"}, start_fetch, sf);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; idle();
    rob_next_pc = '0; inst = '0; inst_addr = '0; pred_next_pc = '0;
    tick();
    rst_in = 1'b0;
    cmp_en = 1'b1;
    expect_lit("reset", 0, 32'h0, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_is_i", out_is_i, 1'b0);

    // First response lands at entry 0.
    resp(32'h0, 32'h0000_0013, 32'h4); tick(); idle();
    expect_lit("first", 1, 32'h4, 1'b1);
    check("first_out_is_i", out_is_i, 1'b1);
    check("first_out_inst", out_inst, 32'h0000_0013);

    // Fill to DEPTH, then one issue resumes fetching at the held pc.
    for (int k = 1; k < 4; k++) begin
      resp(32'(4 * k), 32'h0000_0093 + 32'(k << 7), 32'(4 * k + 4)); tick(); idle();
    end
    expect_lit("full", 4, 32'h10, 1'b0);
    issue_signal = 1'b1; tick(); idle();
    expect_lit("full_pop", 3, 32'h10, 1'b1);
    check("full_pop_head", out_addr, 32'h4);

    // Flush with a request outstanding enters the stale-drop phase.
    issue_signal = 1'b1; tick(); idle();
    check("pre_flush_count", count, 2);
    rob_clear_up = 1'b1; rob_next_pc = 32'h100; tick(); idle();
    expect_lit("flush_drop", 0, 32'h100, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    resp(32'h10, 32'h0000_0013, 32'h14); tick(); idle();
    expect_lit("stale_discard", 0, 32'h100, 1'b1);

    // Flush in the same cycle as a response.
    resp(32'h100, 32'h0000_0013, 32'h104);
    rob_clear_up = 1'b1; rob_next_pc = 32'h200; tick(); idle();
    expect_lit("flush_resp", 0, 32'h200, 1'b1);

    // Simultaneous push/pop at count 2, ten times so both pointers wrap.
    resp(32'h200, 32'h0010_0093, 32'h204); tick(); idle();
    resp(32'h204, 32'h0000_4501, 32'h208); tick(); idle();
    for (int k = 0; k < 10; k++) begin
      resp(32'h208 + 32'(4 * k), (k % 2 == 1) ? 32'h0000_4501 : 32'h0010_0093, 32'h20c + 32'(4 * k));
      issue_signal = 1'b1; tick(); idle();
      check("pushpop_count", count, 2);
      check("pushpop_head", out_addr, 32'h200 + 32'(4 * (k + 1)));
    end
    check("pushpop_pc", pc, 32'h230);

    // rdy_in low freezes everything despite pulses.
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp(32'h230, 32'h0000_0013, 32'h234);
      issue_signal = 1'b1; rob_clear_up = 1'b1; rob_next_pc = 32'h300;
      tick(); idle();
      expect_lit("frozen", 2, 32'h230, 1'b1);
      check("frozen_head", out_addr, 32'h228);
    end
    rdy_in = 1'b1;
    resp(32'h230, 32'h0000_0013, 32'h234); tick(); idle();
    expect_lit("resume", 3, 32'h234, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst_in       = ($urandom_range(0, 199) == 0);
      rdy_in       = ($urandom_range(0, 9) != 0);
      rob_clear_up = ($urandom_range(0, 19) == 0);
      rob_next_pc  = $urandom & 32'h0000_fffc;
      issue_signal = 1'($urandom_range(0, 1));
      inst         = $urandom;
      inst_addr    = m_req ? m_pc : $urandom;
      pred_next_pc = inst_addr + ((inst[1:0] == 2'b11) ? 32'd4 : 32'd2);
      if (!rdy_in)
        fetch_ready = 1'($urandom_range(0, 1));
      else if ((m_req || m_drop) && !(rob_clear_up && m_drop) && $urandom_range(0, 2) == 0)
        fetch_ready = 1'b1;
      tick();
    end
    idle(); rst_in = 1'b0; rdy_in = 1'b1;
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
